// File: rtl/dac_module.sv
`default_nettype none
// ============================================================================
//  Module   : dac_module
//  Purpose  : Transmit-side DAC driver. Signed 16-bit samples enter through a
//             valid/ready handshake into a small FIFO. Each sample is offset,
//             clamped to a 10-bit code and presented to a parallel DAC. The
//             DAC is clocked by a divided conversion clock. dac_d changes only
//             together with the falling edge of dac_clk.
//  Ports    : clk, rst            system clock, synchronous active-high reset
//             enable              run request
//             in_data/in_valid    sample input, qualified by in_valid
//             in_ready            FIFO can accept a sample
//             dac_clk/dac_d       DAC conversion clock and 10-bit code
//             dac_oc              DAC output enable (RUN and DRAIN)
//             underrun            sticky underrun flag, cleared by clr_underrun
//  Options  : DAC_UNDERRUN_MID_EN - drive midscale (512) on underrun and on
//             entry to IDLE, instead of holding the last code.
//  Revision : 1.0 - initial release
// ============================================================================
module dac_module #(
    parameter int DIV_N      = 10,
    parameter int OFFSET     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PRIME      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        dac_clk,
    output logic [9:0]  dac_d,
    output logic        dac_oc,
    output logic        underrun,
    input  logic        clr_underrun
);

    localparam int c_CW = $clog2(DIV_N);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(DIV_N - 1);
    localparam logic [c_CW-1:0] c_CNT_HALF  = c_CW'(DIV_N / 2);
    localparam logic [c_LW-1:0] c_LVL_FULL  = c_LW'(FIFO_DEPTH);
    localparam logic [c_LW-1:0] c_LVL_PRIME = c_LW'(PRIME);
    localparam logic [16:0]     c_OFFSET    = 17'(OFFSET);
    localparam logic [9:0]      c_CODE_MAX  = 10'd1023;
    localparam logic [9:0]      c_CODE_MIN  = 10'd0;
`ifdef DAC_UNDERRUN_MID_EN
    localparam logic [9:0]      c_CODE_MID  = 10'd512;
`endif

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [c_LW-1:0] w_level_nxt;
    logic            r_in_ready;
    logic            r_dac_clk;
    logic [9:0]      r_dac_d;
    logic            r_dac_oc;
    logic            r_underrun;

    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_start;
    logic            w_active;
    logic            w_tick;
    logic            w_underrun_set;
    logic [15:0]     w_head;
    logic [16:0]     w_sum;
    logic [9:0]      w_code;
    logic [9:0]      w_dac_d_nxt;
    logic            w_dac_clk_nxt;
    logic            w_dac_oc_nxt;

    // ------------------------------------------------------------------
    // FIFO bookkeeping. in_ready is registered from the next level, so a
    // pop on a full FIFO cannot admit a push in the same cycle.
    // ------------------------------------------------------------------
    assign w_empty     = (r_level == '0);
    assign w_push      = in_valid && r_in_ready;
    // The start cycle counts as active: cnt is already 0 there, so the
    // first pop happens on the same edge that leaves IDLE.
    assign w_start     = (r_state == c_ST_IDLE) && enable && (r_level >= c_LVL_PRIME);
    assign w_active    = (r_state != c_ST_IDLE) || w_start;
    assign w_tick      = w_active && (r_cnt == '0);
    assign w_pop       = w_tick && !w_empty;
    assign w_underrun_set = w_tick && w_empty && (r_state == c_ST_RUN);
    assign w_level_nxt = r_level + c_LW'(w_push) - c_LW'(w_pop);

    // ------------------------------------------------------------------
    // Offset and clamp of the FIFO head into a 10-bit DAC code.
    // ------------------------------------------------------------------
    assign w_head = r_mem[r_rd_ptr];
    assign w_sum  = {w_head[15], w_head} + c_OFFSET;

    always_comb begin
        w_code = w_sum[9:0];
        if (w_sum[16]) begin
            w_code = c_CODE_MIN;
        end else if (|w_sum[15:10]) begin
            w_code = c_CODE_MAX;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (enable) begin
                    w_state_nxt = c_ST_RUN;
                end else if ((r_cnt == '0) && w_empty) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_dac_oc_nxt  = (w_state_nxt != c_ST_IDLE);
        w_dac_clk_nxt = w_active && (r_cnt >= c_CNT_HALF);
        w_cnt_nxt     = '0;
        if ((w_state_nxt != c_ST_IDLE) && (r_cnt != c_CNT_LAST)) begin
            w_cnt_nxt = r_cnt + c_CW'(1);
        end
        w_dac_d_nxt = r_dac_d;
        if (w_pop) begin
            w_dac_d_nxt = w_code;
        end
`ifdef DAC_UNDERRUN_MID_EN
        else if (w_underrun_set ||
                 ((r_state != c_ST_IDLE) && (w_state_nxt == c_ST_IDLE))) begin
            w_dac_d_nxt = c_CODE_MID;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b0;
            r_dac_clk  <= 1'b0;
            r_dac_d    <= '0;
            r_dac_oc   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_level    <= w_level_nxt;
            r_in_ready <= (w_level_nxt != c_LVL_FULL);
            r_dac_clk  <= w_dac_clk_nxt;
            r_dac_d    <= w_dac_d_nxt;
            r_dac_oc   <= w_dac_oc_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            // Set has priority over a coincident clear.
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Sample storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign in_ready = r_in_ready;
    assign dac_clk  = r_dac_clk;
    assign dac_d    = r_dac_d;
    assign dac_oc   = r_dac_oc;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: doc/dac_module.md
Name: dac_module

Overview:
- Transmit-side counterpart of the ADC capture path.
- Accepts signed sample words through a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample to a 10-bit offset-biased DAC code with saturation.
- Drives a parallel DAC with a divided conversion clock; data changes only at the clock's falling edge, so it is stable at the rising edge.

Parameters:
- DIV_N, 10: clk cycles per dac_clk period; even, ≥4.
- OFFSET, 16: added to each sample before clamping; inverse of the ADC path's −16.
- FIFO_DEPTH, 4: sample buffer entries; power of 2, ≥2.
- PRIME, 2: FIFO fill level needed to leave IDLE; 1..FIFO_DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run request.
- in_data  in  16  signed two's-complement sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept a sample.
- dac_clk  out  1  DAC conversion clock.
- dac_d  out  10  DAC code.
- dac_oc  out  1  DAC output enable; high in RUN and DRAIN.
- underrun  out  1  sticky underrun flag.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Reset values (rst high at rising clk): dac_clk=0, dac_d=0, dac_oc=0, underrun=0, in_ready=0, FIFO empty, cnt=0, state=IDLE. After reset, in_ready = !full.
- Write handshake: a sample is accepted on a cycle with in_valid && in_ready and becomes poppable the next cycle. When full, in_ready=0 and no write occurs. Simultaneous push and pop on a full FIFO: pop succeeds and push is still refused, because in_ready is derived from the registered level.
- Clock divider: cnt counts 0..DIV_N−1 and wraps. dac_clk is registered as (cnt < DIV_N/2) ? 0 : 1. With DIV_N=10, dac_clk is low for 5 clk cycles and high for 5. cnt and dac_clk are held at 0 in IDLE.
- Update point: on the cnt==0 cycle (the dac_clk falling edge), one entry is popped if the FIFO is non-empty.
- Conversion: sum = sign-extended in_data + OFFSET, 17-bit signed. If sum<0, code=0; if sum>1023, code=1023; otherwise code=sum[9:0]. dac_d is registered with the code in the same cycle as the pop.
- Underrun: if the FIFO is empty at cnt==0 in RUN, dac_d holds its value and underrun is set. clr_underrun clears the flag; if set and clear occur together, set wins.
- State machine:
  - IDLE → RUN when enable=1 and FIFO level ≥ PRIME. cnt starts at 0, so the first pop is that same cycle.
  - RUN → DRAIN when enable=0.
  - DRAIN: keeps popping at cnt==0 and does not flag underrun. DRAIN → IDLE on the first cnt==0 with the FIFO empty. DRAIN → RUN if enable returns to 1.
  - IDLE: dac_oc=0; dac_d keeps its last value.
- Latency: at most DIV_N cycles from FIFO non-empty to the dac_d update while in RUN.
- Reset mid-operation: all state returns to the reset values within one cycle; FIFO contents are discarded.

Optional Feature:
- Macro: DAC_UNDERRUN_MID_EN.
- Defined: on an underrun in RUN, dac_d is loaded with midscale 512 instead of holding; the flag behaves identically. On entering IDLE, dac_d is also loaded with 512.
- Undefined: dac_d holds its last value in both cases, as described above.

Test Plan:
- Basic stream, DIV_N=10: reset, enable=1, push 100, 200, 300. Required: dac_d shows 116, 216, 316 at successive cnt==0 edges exactly 10 clk cycles apart; dac_clk is 5 cycles low / 5 cycles high; dac_oc=1 from the first pop.
- Saturation: push −20, 1010, 32767, −32768. Required: codes 0, 1023, 1023, 0.
- Backpressure: hold in_valid=1 with 6 distinct samples and enable=0. Required: after 4 accepts in_ready=0 and no overwrite; after enable=1 all 4 samples are output in order, then the remaining 2.
- Underrun: enable=1, push only 2 samples. Required: underrun=1 at the first empty cnt==0 and dac_d holds the 2nd code (512 with DAC_UNDERRUN_MID_EN). clr_underrun pulse → 0; clr_underrun coincident with a new underrun → stays 1.
- Drain and restart: enable drops with 3 samples queued. Required: all 3 are output, then IDLE with dac_oc=0 and dac_clk=0; re-enable with 1 sample and PRIME=2 → stays IDLE until a 2nd sample arrives.
- Mid-run reset: assert rst for 1 cycle during RUN. Required: next cycle dac_d=0, dac_clk=0, dac_oc=0, in_ready=0, then in_ready=1; previously queued samples are never output.
